// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Parametrised multi-cycle ALU. Single-cycle arithmetic/logic
//               opcodes produce a registered result one cycle after accept;
//               mulu (shift-add) and divu (restoring) iterate one bit per
//               cycle for WIDTH cycles. Operands enter via valid/ready, and
//               every result is announced by a one-cycle out_valid pulse.
// Ports       : clk, reset (sync, active-high)
//               in_valid / in_ready : operand handshake
//               X, Y [WIDTH], ALUctr [4] : operands and opcode
//               out_valid : pulse when R/Overflow/Zero were just written
//               R [WIDTH], Overflow, Zero : registered result and flags
//               busy : high during a multi-cycle operation (== ~in_ready)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       ALUctr,
  output logic             out_valid,
  output logic [WIDTH-1:0] R,
  output logic             Overflow,
  output logic             Zero,
  output logic             busy
);

  localparam int               c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  localparam logic [3:0] c_OP_ADDU = 4'b0000;
  localparam logic [3:0] c_OP_ADD  = 4'b0001;
  localparam logic [3:0] c_OP_OR   = 4'b0010;
  localparam logic [3:0] c_OP_AND  = 4'b0011;
  localparam logic [3:0] c_OP_SUBU = 4'b0100;
  localparam logic [3:0] c_OP_SUB  = 4'b0101;
  localparam logic [3:0] c_OP_SLTU = 4'b0110;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_XOR  = 4'b1000;
  localparam logic [3:0] c_OP_NOR  = 4'b1001;
  localparam logic [3:0] c_OP_MULU = 4'b1010;
  localparam logic [3:0] c_OP_DIVU = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  // Work register: upper half is accumulator (mul) or partial remainder (div),
  // lower half is the multiplier being shifted out (mul) or the dividend being
  // replaced by quotient bits (div).
  logic [2*WIDTH-1:0]   wk_q, wk_d;
  logic [WIDTH-1:0]     b_q, b_d;      // multiplicand or divisor
  logic                 dz_q, dz_d;    // divide-by-zero seen at accept
  logic [WIDTH-1:0]     r_q, r_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 ov_q, ov_d;

  // ---------------- single-cycle result ----------------
  logic [WIDTH-1:0] w_sum, w_dif, w_res;
  logic             w_ovf;

  assign w_sum = X + Y;
  assign w_dif = X - Y;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALUctr)
      c_OP_ADDU: w_res = w_sum;
      c_OP_ADD: begin
        w_res = w_sum;
        w_ovf = (X[WIDTH-1] == Y[WIDTH-1]) && (w_sum[WIDTH-1] != X[WIDTH-1]);
      end
      c_OP_OR:   w_res = X | Y;
      c_OP_AND:  w_res = X & Y;
      c_OP_SUBU: w_res = w_dif;
      c_OP_SUB: begin
        w_res = w_dif;
        w_ovf = (X[WIDTH-1] != Y[WIDTH-1]) && (w_dif[WIDTH-1] != X[WIDTH-1]);
      end
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (X < Y)};
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
      c_OP_XOR:  w_res = X ^ Y;
      c_OP_NOR:  w_res = ~(X | Y);
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // ---------------- iteration steps ----------------
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_mstep;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_sub;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_dstep;

  // Shift-add: add multiplicand when the current multiplier LSB is set,
  // then shift the whole accumulator right by one.
  assign w_madd  = {1'b0, wk_q[2*WIDTH-1:WIDTH]} + (wk_q[0] ? {1'b0, b_q} : '0);
  assign w_mstep = {w_madd, wk_q[WIDTH-1:1]};

  // Restoring division. An explicit compare (rather than the subtractor's top
  // bit) keeps the divisor-zero case producing all-ones quotient bits.
  assign w_shift = {wk_q[2*WIDTH-1:WIDTH], wk_q[WIDTH-1]};
  assign w_sub   = w_shift - {1'b0, b_q};
  assign w_ge    = (w_shift >= {1'b0, b_q});
  assign w_dstep = w_ge ? {w_sub[WIDTH-1:0],   wk_q[WIDTH-2:0], 1'b1}
                        : {w_shift[WIDTH-1:0], wk_q[WIDTH-2:0], 1'b0};

  // ---------------- next-state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wk_d    = wk_q;
    b_d     = b_q;
    dz_d    = dz_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    ov_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          case (ALUctr)
            c_OP_MULU: begin
              wk_d    = {{WIDTH{1'b0}}, Y};
              b_d     = X;
              state_d = S_MUL;
            end
            c_OP_DIVU: begin
              wk_d    = {{WIDTH{1'b0}}, X};
              b_d     = Y;
              dz_d    = (Y == '0);
              state_d = S_DIV;
            end
            default: begin
              r_d    = w_res;
              ovf_d  = w_ovf;
              zero_d = (w_res == '0);
              ov_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        wk_d  = w_mstep;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_LAST) begin
          state_d = S_IDLE;
          r_d     = w_mstep[WIDTH-1:0];
          ovf_d   = |w_mstep[2*WIDTH-1:WIDTH];
          zero_d  = (w_mstep[WIDTH-1:0] == '0);
          ov_d    = 1'b1;
        end
      end
      S_DIV: begin
        wk_d  = w_dstep;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_LAST) begin
          state_d = S_IDLE;
          r_d     = w_dstep[WIDTH-1:0];
          ovf_d   = dz_q;
          zero_d  = (w_dstep[WIDTH-1:0] == '0);
          ov_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wk_q    <= '0;
      b_q     <= '0;
      dz_q    <= 1'b0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wk_q    <= wk_d;
      b_q     <= b_d;
      dz_q    <= dz_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = ~in_ready;
  assign out_valid = ov_q;
  assign R         = r_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc. Two instances (WIDTH=32 and
//               WIDTH=8) are checked every cycle against a cycle-level model
//               built from plain arithmetic, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  iv, rdy, ov, ovf, zr, bz;
  logic [31:0] x0, y0, r0;
  logic [7:0]  x1, y1, r1;
  logic [3:0]  op0, op1;

  alu_mc #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]),
    .X(x0), .Y(y0), .ALUctr(op0), .out_valid(ov[0]), .R(r0),
    .Overflow(ovf[0]), .Zero(zr[0]), .busy(bz[0])
  );

  alu_mc #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]),
    .X(x1), .Y(y1), .ALUctr(op1), .out_valid(ov[1]), .R(r1),
    .Overflow(ovf[1]), .Zero(zr[1]), .busy(bz[1])
  );

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] r_of(input int d);
    return (d == 0) ? {32'b0, r0} : {56'b0, r1};
  endfunction

  // Reference arithmetic straight from the opcode table.
  function automatic void calc(input int w, input logic [3:0] op,
                               input logic [63:0] xi, input logic [63:0] yi,
                               output logic [63:0] r, output logic o);
    logic [63:0] m, sb, x, y, p;
    m  = (64'd1 << w) - 64'd1;
    sb = 64'd1 << (w - 1);
    x  = xi & m;
    y  = yi & m;
    o  = 1'b0;
    r  = 64'd0;
    case (op)
      4'd0:  r = (x + y) & m;
      4'd1:  begin r = (x + y) & m; o = (((x ^ y) & sb) == 0) && (((r ^ x) & sb) != 0); end
      4'd2:  r = x | y;
      4'd3:  r = x & y;
      4'd4:  r = (x - y) & m;
      4'd5:  begin r = (x - y) & m; o = (((x ^ y) & sb) != 0) && (((r ^ x) & sb) != 0); end
      4'd6:  r = (x < y) ? 64'd1 : 64'd0;
      4'd7:  r = ((x ^ sb) < (y ^ sb)) ? 64'd1 : 64'd0;  // signed compare via bias
      4'd8:  r = x ^ y;
      4'd9:  r = ~(x | y) & m;
      4'd10: begin p = x * y; r = p & m; o = (p >> w) != 0; end
      4'd11: begin
        if (y == 0) begin r = m; o = 1'b1; end
        else r = x / y;
      end
      default: begin r = 64'd0; o = 1'b0; end
    endcase
  endfunction

  // Cycle-level model: state per instance.
  bit          m_ready[2];
  bit          m_v[2];
  int          m_cnt[2];
  logic [63:0] m_r[2], m_pr[2];
  logic        m_o[2], m_z[2], m_po[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        v;
      logic [3:0]  op;
      logic [63:0] x, y, res;
      logic        o;
      int          w;
      w  = (d == 0) ? 32 : 8;
      v  = iv[d];
      op = (d == 0) ? op0 : op1;
      x  = (d == 0) ? {32'b0, x0} : {56'b0, x1};
      y  = (d == 0) ? {32'b0, y0} : {56'b0, y1};
      if (reset) begin
        m_ready[d] = 1'b1; m_cnt[d] = 0; m_v[d] = 1'b0;
        m_r[d] = 64'd0; m_o[d] = 1'b0; m_z[d] = 1'b1;
      end else begin
        m_v[d] = 1'b0;
        if (!m_ready[d]) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            m_ready[d] = 1'b1;
            m_r[d] = m_pr[d]; m_o[d] = m_po[d]; m_z[d] = (m_pr[d] == 0);
            m_v[d] = 1'b1;
          end
        end else if (v) begin
          calc(w, op, x, y, res, o);
          if (op == 4'd10 || op == 4'd11) begin
            m_pr[d] = res; m_po[d] = o; m_cnt[d] = w; m_ready[d] = 1'b0;
          end else begin
            m_r[d] = res; m_o[d] = o; m_z[d] = (res == 0); m_v[d] = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_chk) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("w%0d out_valid", d), {63'b0, ov[d]},  {63'b0, m_v[d]});
        chk($sformatf("w%0d in_ready", d),  {63'b0, rdy[d]}, {63'b0, m_ready[d]});
        chk($sformatf("w%0d busy", d),      {63'b0, bz[d]},  {63'b0, ~m_ready[d]});
        chk($sformatf("w%0d R", d),         r_of(d),         m_r[d]);
        chk($sformatf("w%0d Overflow", d),  {63'b0, ovf[d]}, {63'b0, m_o[d]});
        chk($sformatf("w%0d Zero", d),      {63'b0, zr[d]},  {63'b0, m_z[d]});
      end
    end
  end

  // Drive one operation and return at the negedge after it is accepted.
  // in_valid is left high so consecutive calls are back-to-back.
  task automatic send(input int d, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    if (d == 0) begin op0 = op; x0 = x; y0 = y; end
    else        begin op1 = op; x1 = x[7:0]; y1 = y[7:0]; end
    iv[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 200) begin @(negedge clk); n++; end
    chk("ready wait", {63'b0, rdy[d]}, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(input int d, input string nm, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] er, input logic eo, input int ebusy);
    int n, bc;
    send(d, op, x, y);
    iv[d] = 1'b0;
    n = 0; bc = 0;
    while (!ov[d] && n < 200) begin
      if (!rdy[d]) bc++;
      @(negedge clk);
      n++;
    end
    chk({nm, " out_valid"}, {63'b0, ov[d]}, 64'd1);
    chk({nm, " R"}, r_of(d), er);
    chk({nm, " Overflow"}, {63'b0, ovf[d]}, {63'b0, eo});
    chk({nm, " Zero"}, {63'b0, zr[d]}, {63'b0, (er == 0)});
    chk({nm, " busy cycles"}, 64'(bc), 64'(ebusy));
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] pr;
    logic        po;
    reset = 1'b1; iv = 2'b00;
    x0 = '0; y0 = '0; op0 = '0; x1 = '0; y1 = '0; op1 = '0;

    // Hand-computed pins on the reference arithmetic.
    calc(32, 4'd1, 64'h80000000, 64'hF0000000, pr, po);
    chk("model add", {pr[62:0], po}, {63'h70000000, 1'b1});
    calc(32, 4'd7, 64'h80000000, 64'h10000000, pr, po);
    chk("model slt", pr, 64'd1);
    calc(8, 4'd10, 64'h10, 64'h10, pr, po);
    chk("model mulu8", {pr[62:0], po}, {63'h0, 1'b1});
    calc(32, 4'd11, 64'd5, 64'd0, pr, po);
    chk("model divu0", {pr[62:0], po}, {63'hFFFFFFFF, 1'b1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset R", r_of(0), 64'd0);
    chk("reset Zero", {63'b0, zr[0]}, 64'd1);
    chk("reset in_ready", {63'b0, rdy[0]}, 64'd1);
    chk("reset out_valid", {63'b0, ov[0]}, 64'd0);
    run_chk = 1'b1;

    do_op(0, "add",  4'd1,  32'h80000000, 32'hF0000000, 64'h70000000, 1'b1, 0);
    do_op(0, "addu", 4'd0,  32'h80000000, 32'hF0000000, 64'h70000000, 1'b0, 0);
    do_op(0, "sub",  4'd5,  32'h80000000, 32'h10000000, 64'h70000000, 1'b1, 0);
    do_op(0, "slt",  4'd7,  32'h80000000, 32'h10000000, 64'd1,        1'b0, 0);
    do_op(0, "sltu", 4'd6,  32'h80000000, 32'h10000000, 64'd0,        1'b0, 0);
    do_op(0, "mulu big", 4'd10, 32'h00010000, 32'h00010000, 64'd0,    1'b1, 32);
    do_op(0, "mulu 7x6", 4'd10, 32'd7, 32'd6, 64'd42,                 1'b0, 32);
    do_op(0, "divu 100/7", 4'd11, 32'd100, 32'd7, 64'd14,             1'b0, 32);
    do_op(0, "divu 5/0", 4'd11, 32'd5, 32'd0, 64'hFFFFFFFF,           1'b1, 32);
    do_op(0, "nor",  4'd9,  32'h0000FFFF, 32'hFF000000, 64'h00FF0000, 1'b0, 0);
    do_op(0, "rsvd", 4'd12, 32'h12345678, 32'h1,        64'd0,        1'b0, 0);

    // or held valid while mulu runs, then three back-to-back xors.
    send(0, 4'd10, 32'd3, 32'd5);
    send(0, 4'd2, 32'h000000F0, 32'h0000000F);
    chk("held or R", r_of(0), 64'hFF);
    chk("held or out_valid", {63'b0, ov[0]}, 64'd1);
    send(0, 4'd8, 32'h0000FF00, 32'h00000FF0);
    chk("xor1 R", r_of(0), 64'hF0F0);
    send(0, 4'd8, 32'd1, 32'd1);
    chk("xor2 R", r_of(0), 64'h0);
    chk("xor2 Zero", {63'b0, zr[0]}, 64'd1);
    send(0, 4'd8, 32'hAAAAAAAA, 32'h55555555);
    chk("xor3 R", r_of(0), 64'hFFFFFFFF);
    chk("xor3 out_valid", {63'b0, ov[0]}, 64'd1);
    iv[0] = 1'b0;
    @(negedge clk);

    // Reset ten cycles into a divide.
    send(0, 4'd11, 32'd1000, 32'd3);
    iv[0] = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort out_valid", {63'b0, ov[0]}, 64'd0);
    chk("abort R", r_of(0), 64'd0);
    chk("abort Zero", {63'b0, zr[0]}, 64'd1);
    chk("abort in_ready", {63'b0, rdy[0]}, 64'd1);
    repeat (40) @(negedge clk);
    do_op(0, "addu 1+1", 4'd0, 32'd1, 32'd1, 64'd2, 1'b0, 0);

    // Narrow instance.
    do_op(1, "w8 mulu 7x6", 4'd10, 32'd7, 32'd6, 64'd42,     1'b0, 8);
    do_op(1, "w8 mulu 16x16", 4'd10, 32'h10, 32'h10, 64'd0,  1'b1, 8);
    do_op(1, "w8 divu 100/7", 4'd11, 32'd100, 32'd7, 64'd14, 1'b0, 8);
    do_op(1, "w8 divu 5/0", 4'd11, 32'd5, 32'd0, 64'hFF,     1'b1, 8);
    do_op(1, "w8 add", 4'd1, 32'h70, 32'h10, 64'h80,         1'b1, 0);

    repeat (3) @(negedge clk);
    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the CPU datapath. It extends the single-cycle X/Y/ALUctr ALU in three ways: a generic WIDTH, a 4-bit opcode space, and iterative unsigned multiply and divide. Operands enter through a valid/ready handshake. Results are registered and announced with a one-cycle out_valid pulse, so the control unit can stall the pipeline while a multi-cycle operation runs.

## Interface
- WIDTH, 32: operand and result width in bits; must be at least 4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode valid this cycle.
- in_ready  out  1  unit can accept an operation this cycle.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- ALUctr  in  4  opcode.
- out_valid  out  1  one-cycle pulse: R, Overflow and Zero were just updated.
- R  out  WIDTH  result; holds its value until the next result.
- Overflow  out  1  overflow/error flag for the result.
- Zero  out  1  high when R == 0; registered together with R.
- busy  out  1  high when state is MUL or DIV; always equal to ~in_ready.

## Operation
- An operation is accepted on a rising edge where in_valid & in_ready.
  - X, Y and ALUctr are sampled at that edge.
  - While not ready, in_valid is ignored. No queuing.
- States:
  - IDLE: in_ready = 1.
  - MUL and DIV: in_ready = 0.
- Single-cycle opcodes: the unit stays in IDLE and the result is registered at the accept edge.
  - 0000 addu: R = X+Y; Overflow = 0.
  - 0001 add: R = X+Y; Overflow = signed overflow, i.e. both operand sign bits equal and the result sign bit differs.
  - 0010 or.
  - 0011 and.
  - 0100 subu: R = X−Y; Overflow = 0.
  - 0101 sub: R = X−Y; Overflow = signed overflow.
  - 0110 sltu: R = {0…, X<Y unsigned}.
  - 0111 slt: R = {0…, X<Y signed}.
  - 1000 xor.
  - 1001 nor.
  - For 0010, 0011, 1000, 1001 (bitwise ops), and for 0110 and 0111: Overflow = 0.
  - 1100–1111 reserved: R = 0, Overflow = 0, Zero = 1, out_valid still pulses.
- 1010 mulu: IDLE→MUL.
  - Shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH iterations.
  - R = low WIDTH bits of the product; Overflow = (high WIDTH bits ≠ 0).
- 1011 divu: IDLE→DIV.
  - Restoring division, one quotient bit per cycle, WIDTH iterations. R = quotient; the remainder is discarded.
  - Y = 0: the algorithm runs unchanged. R = all ones, Overflow = 1, same latency. Overflow = 0 for every other divu.
- MUL/DIV → IDLE on the edge that performs the last iteration. That same edge writes R, Overflow and Zero and sets out_valid.
- Iteration count comes from an internal counter of width $clog2(WIDTH+1), which restarts at 0 on every accept.
- Every out_valid pulse rewrites Overflow and Zero; flags are never sticky.

## Timing
- Reset (synchronous, overrides everything): state = IDLE, counter = 0, R = 0, Overflow = 0, Zero = 1, out_valid = 0, in_ready = 1, busy = 0.
- Reset during MUL or DIV aborts the operation. No out_valid is produced, and R keeps the reset value 0.
- Single-cycle ops, accepted at edge k:
  - out_valid is high in the cycle after edge k (latency 1).
  - Back-to-back accepts every cycle give one out_valid per cycle.
- mulu/divu, accepted at edge k:
  - Iterations occur at edges k+1 … k+WIDTH.
  - out_valid is high in the cycle after edge k+WIDTH; in_ready is high in that same cycle, so the next op can be accepted at edge k+WIDTH+1.
  - in_ready is low for exactly WIDTH cycles.
- out_valid is high only for the single cycle after a result-writing edge, never longer.
- Outputs are registered only; there is no combinational path from X, Y or ALUctr to R, Overflow or Zero.

## Test plan
- Reset, then add with X=0x80000000, Y=0xF0000000 → R=0x70000000, Overflow=1, Zero=0. Same operands with addu → Overflow=0. One out_valid per op.
- sub with X=0x80000000, Y=0x10000000 → R=0x70000000, Overflow=1. slt on the same operands → R=1. sltu → R=0, Zero=1.
- mulu with X=0x00010000, Y=0x00010000 → after exactly 32 cycles of in_ready=0: R=0, Overflow=1, Zero=1. mulu with X=7, Y=6 → R=42, Overflow=0.
- divu with X=100, Y=7 → R=14, Overflow=0. divu with X=5, Y=0 → R=0xFFFFFFFF, Overflow=1, with 32-cycle latency.
- Hold in_valid high with an or op during a mulu → it is not accepted until in_ready returns. Then issue 3 back-to-back xor ops → 3 consecutive out_valid pulses with the correct R values.
- Assert reset 10 cycles into a divu → no out_valid. R=0, Zero=1, in_ready=1 on the next cycle. A following addu of 1+1 → R=2.
- Rerun the multiply and divide scenarios with WIDTH=8 → latency 8, and mulu 0x10·0x10 → R=0x00, Overflow=1.
